instruction_fetch: RTL and testbench

Instruction fetch unit for the mesh-node CPU. It holds the program counter and issues word reads to the synchronous instruction memory. It hands 32-bit instruction words, bit 0 being the MSB, to the instruction decoder. It absorbs downstream stalls with a one-entry hold register and redirects on resolved bez/bnez branches, squashing wrong-path words as NOPs.

---
 rtl/instruction_fetch.sv | 162 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, synchronous imem issue, one-entry stall hold, branch redirect.
// Optional IFETCH_PERF_EN adds saturating stall_cycles / squash_count counters.
module instruction_fetch #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [0:PC_WIDTH-1] RESET_PC = '0,
  parameter logic [0:31]         NOP_WORD = 32'hF000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [0:PC_WIDTH-1] branch_target,
  output logic                imem_en,
  output logic [0:PC_WIDTH-1] imem_addr,
  input  logic [0:31]         imem_data,
  output logic [0:31]         instruction,
  output logic [0:PC_WIDTH-1] instruction_pc,
  output logic                instruction_valid
`ifdef IFETCH_PERF_EN
  ,
  output logic [0:15]         stall_cycles,
  output logic [0:15]         squash_count
`endif
);

  localparam int unsigned         WORD_WIDTH = 32;
  localparam logic [0:PC_WIDTH-1] PC_STEP    = PC_WIDTH'(4);
  localparam logic [0:PC_WIDTH-1] ALIGN_MASK = ~(PC_WIDTH'(3));

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_REDIRECT} state_e;

  state_e                state_q, state_d;
  logic [0:PC_WIDTH-1]   pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [0:PC_WIDTH-1]   inflight_pc_q, inflight_pc_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [0:WORD_WIDTH-1] hold_word_q, hold_word_d;
  logic [0:PC_WIDTH-1]   hold_pc_q, hold_pc_d;
  logic                  issue;

  // Presented word: hold has priority over the returning read.
  always_comb begin
    instruction       = NOP_WORD;
    instruction_pc    = '0;
    instruction_valid = 1'b0;
    if (reset) begin
      if (hold_valid_q) begin
        instruction       = hold_word_q;
        instruction_pc    = hold_pc_q;
        instruction_valid = 1'b1;
      end else if (inflight_q) begin
        instruction       = imem_data;
        instruction_pc    = inflight_pc_q;
        instruction_valid = 1'b1;
      end
    end
  end

  // Next-state: redirect beats stall beats issue.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    hold_valid_d  = hold_valid_q;
    hold_word_d   = hold_word_q;
    hold_pc_d     = hold_pc_q;
    issue         = 1'b0;
    if (branch_taken) begin
      state_d      = ST_REDIRECT;
      pc_d         = branch_target & ALIGN_MASK;
      inflight_d   = 1'b0;
      hold_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (stall) begin
            inflight_d = 1'b0;
          end else begin
            issue        = 1'b1;
            hold_valid_d = 1'b0;
            state_d      = ST_RUN;
          end
        end
        // REDIRECT behaves as RUN with nothing valid to capture.
        default: begin
          state_d = ST_RUN;
          if (stall) begin
            inflight_d = 1'b0;
            if (instruction_valid) begin
              hold_valid_d = 1'b1;
              hold_word_d  = instruction;
              hold_pc_d    = instruction_pc;
              state_d      = ST_HOLD;
            end
          end else begin
            issue = 1'b1;
          end
        end
      endcase
    end
    if (issue) begin
      pc_d          = PC_WIDTH'(pc_q + PC_STEP);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  assign imem_en   = issue & reset;
  assign imem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      hold_valid_q  <= 1'b0;
      hold_word_q   <= NOP_WORD;
      hold_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      hold_valid_q  <= hold_valid_d;
      hold_word_q   <= hold_word_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [0:15] stall_cycles_q, stall_cycles_d;
  logic [0:15] squash_count_q, squash_count_d;

  // Saturating counters; a squash is a redirect that drops an inflight or held word.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    squash_count_d = squash_count_q;
    if (stall && instruction_valid && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = 16'(stall_cycles_q + 16'd1);
    end
    if (branch_taken && (inflight_q || hold_valid_q) && (squash_count_q != 16'hFFFF)) begin
      squash_count_d = 16'(squash_count_q + 16'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      squash_count_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      squash_count_q <= squash_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign squash_count = squash_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed steps, scoreboard of issued reads vs presented words.
module tb_instruction_fetch;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [0:31] branch_target;
  logic        imem_en;
  logic [0:31] imem_addr;
  logic [0:31] imem_data;
  logic [0:31] instruction;
  logic [0:31] instruction_pc;
  logic        instruction_valid;

  logic        w_stall;
  logic        w_bt;
  logic [0:7]  w_target;
  logic        w_en;
  logic [0:7]  w_addr;
  logic [0:31] w_data;
  logic [0:31] w_instr;
  logic [0:7]  w_pc;
  logic        w_valid;

  int   n_checks;
  int   n_errors;
  exp_t q[$];
  exp_t wq[$];

`ifdef IFETCH_PERF_EN
  logic [0:15] stall_cycles, squash_count;
  logic [0:15] w_stall_cycles, w_squash_count;
`endif

  instruction_fetch u_dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_en           (imem_en),
    .imem_addr         (imem_addr),
    .imem_data         (imem_data),
    .instruction       (instruction),
    .instruction_pc    (instruction_pc),
    .instruction_valid (instruction_valid)
`ifdef IFETCH_PERF_EN
    ,
    .stall_cycles      (stall_cycles),
    .squash_count      (squash_count)
`endif
  );

  instruction_fetch #(.PC_WIDTH(8), .RESET_PC(8'hF8)) u_wrap (
    .clk               (clk),
    .reset             (reset),
    .stall             (w_stall),
    .branch_taken      (w_bt),
    .branch_target     (w_target),
    .imem_en           (w_en),
    .imem_addr         (w_addr),
    .imem_data         (w_data),
    .instruction       (w_instr),
    .instruction_pc    (w_pc),
    .instruction_valid (w_valid)
`ifdef IFETCH_PERF_EN
    ,
    .stall_cycles      (w_stall_cycles),
    .squash_count      (w_squash_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories: main word n lives at byte 4n, wrap memory returns the address.
  always @(posedge clk) begin
    imem_data <= imem_en ? 32'(imem_addr >> 2) : 32'hDEAD_BEEF;
    w_data    <= w_en ? {24'h0, w_addr} : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic s, input logic bt, input logic [31:0] tgt,
                      input logic e_en, input logic [31:0] e_addr, input logic e_valid);
    exp_t f;
    @(negedge clk);
    reset = rst; stall = s; branch_taken = bt; branch_target = tgt;
    #1;
    chk("imem_en", 64'(imem_en), 64'(e_en));
    chk("imem_addr", 64'(imem_addr), 64'(e_addr));
    chk("instruction_valid", 64'(instruction_valid), 64'(e_valid));
    if (e_en) begin
      f.word = e_addr >> 2;
      f.pc   = e_addr;
      q.push_back(f);
    end
    if (e_valid) begin
      n_checks++;
      assert (q.size() > 0) else begin
        n_errors++;
        $error("FAIL scoreboard_underflow observed=valid expected=no_word");
      end
      if (q.size() > 0) begin
        f = q[0];
        chk("instruction", 64'(instruction), 64'(f.word));
        chk("instruction_pc", 64'(instruction_pc), 64'(f.pc));
        if (!s) void'(q.pop_front());
      end
    end else begin
      chk("nop_word", 64'(instruction), 64'(32'hF000_0000));
      chk("nop_pc", 64'(instruction_pc), 64'(0));
    end
    if (bt || !rst) q.delete();
  endtask

  task automatic wstep(input logic [7:0] e_addr, input logic e_valid);
    exp_t f;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("wrap_imem_en", 64'(w_en), 64'(1));
    chk("wrap_imem_addr", 64'(w_addr), 64'(e_addr));
    chk("wrap_valid", 64'(w_valid), 64'(e_valid));
    f.word = 32'(e_addr);
    f.pc   = 32'(e_addr);
    wq.push_back(f);
    if (e_valid && wq.size() > 0) begin
      f = wq.pop_front();
      chk("wrap_instruction", 64'(w_instr), 64'(f.word));
      chk("wrap_instruction_pc", 64'(w_pc), 64'(f.pc));
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    w_stall = 1'b0; w_bt = 1'b0; w_target = '0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Straight line.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h04, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1);

    // Mid-operation reset discards the inflight read.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h14, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 1'b0);

    // Stall three cycles on word 2, then release.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h04, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0C, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b1);

    // Branch to 0x40 while pc=0x10.
    step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h10, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44, 1'b1);
`ifdef IFETCH_PERF_EN
    chk("squash_count_1", 64'(squash_count), 64'(1));
`endif
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h48, 1'b1);

    // Branch under stall to unaligned 0x22; no fetch until stall drops.
    step(1'b1, 1'b1, 1'b1, 32'h22, 1'b0, 32'h4C, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h20, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h20, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h24, 1'b1);
`ifdef IFETCH_PERF_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(4));
    chk("squash_count_2", 64'(squash_count), 64'(2));
`endif

    // 8-bit pc wraps F8, FC, 00, 04.
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    wstep(8'hF8, 1'b0);
    wstep(8'hFC, 1'b1);
    wstep(8'h00, 1'b1);
    wstep(8'h04, 1'b1);
    wstep(8'h08, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
